// File: rtl/soc_bus_router.sv
// Single-master MMIO router: decodes each request against the slave address map and forwards it
// to one slave at a time, terminating unmapped or silent targets with an error response.
module soc_bus_router #(
  parameter int          SLAVES                       = 3,
  parameter logic [31:0] LOW_ADDRESS  [SLAVES]        = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000},
  parameter logic [31:0] HIGH_ADDRESS [SLAVES]        = '{32'h0000_0FFC, 32'h0000_100C, 32'h0000_2FFC},
  parameter int          TIMEOUT_CYCLES               = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   m_req_valid_i,
  output logic                   m_req_ready_o,
  input  logic                   m_req_write_i,
  input  logic [31:0]            m_req_addr_i,
  input  logic [31:0]            m_req_wdata_i,
  input  logic [3:0]             m_req_strb_i,
  output logic                   m_rsp_valid_o,
  input  logic                   m_rsp_ready_i,
  output logic [31:0]            m_rsp_data_o,
  output logic                   m_rsp_error_o,
  output logic [SLAVES-1:0]      s_req_valid_o,
  input  logic [SLAVES-1:0]      s_req_ready_i,
  output logic                   s_req_write_o,
  output logic [31:0]            s_req_addr_o,
  output logic [31:0]            s_req_wdata_o,
  output logic [3:0]             s_req_strb_o,
  input  logic [SLAVES-1:0]      s_rsp_valid_i,
  output logic [SLAVES-1:0]      s_rsp_ready_o,
  input  logic [32*SLAVES-1:0]   s_rsp_data_i,
  input  logic [SLAVES-1:0]      s_rsp_error_i,
  output logic                   bus_error_o,
  output logic [31:0]            bus_error_addr_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_REQUEST  = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_RESPOND  = 3'd4
  } state_t;

  state_t              r_state;
  logic [SLAVES-1:0]   r_sel;
  logic [CW-1:0]       r_cnt;
  logic                r_write;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_strb;
  logic [31:0]         r_rsp_data;
  logic                r_rsp_error;
  logic                r_rsp_valid;
  logic                r_req_ready;
  logic [SLAVES-1:0]   r_s_req_valid;
  logic [SLAVES-1:0]   r_s_rsp_ready;
  logic                r_bus_error;
  logic [31:0]         r_bus_error_addr;

  state_t              w_state_nxt;
  logic [SLAVES-1:0]   w_sel_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_latch;
  logic [31:0]         w_rsp_data_nxt;
  logic                w_rsp_error_nxt;
  logic                w_bus_error;
  logic [31:0]         w_word_addr;
  logic [SLAVES-1:0]   w_match;
  logic                w_hit;
  logic [31:0]         w_rdata;
  logic                w_rerr;
  logic                w_req_hit;
  logic                w_rsp_hit;
  logic                w_timeout;

  // Byte offset bits never influence which slave owns an address.
  assign w_word_addr = {r_addr[31:2], 2'b00};
  assign w_rerr      = |(s_rsp_error_i & r_sel);
  assign w_req_hit   = |(s_req_ready_i & r_sel);
  assign w_rsp_hit   = |(s_rsp_valid_i & r_sel);
  assign w_timeout   = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Address decode: lowest-index matching range wins.
  always_comb begin
    w_match = '0;
    w_hit   = 1'b0;
    for (int i = 0; i < SLAVES; i++) begin
      if (!w_hit && (w_word_addr >= LOW_ADDRESS[i]) && (w_word_addr <= HIGH_ADDRESS[i])) begin
        w_match[i] = 1'b1;
        w_hit      = 1'b1;
      end else begin
        w_match[i] = 1'b0;
      end
    end
  end

  // Read-data mux from the selected slave.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < SLAVES; i++) begin
      w_rdata = w_rdata | (s_rsp_data_i[32*i +: 32] & {32{r_sel[i]}});
    end
  end

  // Next-state and transaction bookkeeping.
  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_cnt_nxt       = r_cnt;
    w_latch         = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_error_nxt = r_rsp_error;
    w_bus_error     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m_req_valid_i) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_DECODE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (w_hit) begin
          w_sel_nxt   = w_match;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REQUEST;
        end else begin
          w_rsp_data_nxt  = 32'h0000_0000;
          w_rsp_error_nxt = 1'b1;
          w_bus_error     = 1'b1;
          w_state_nxt     = ST_RESPOND;
        end
      end
      ST_REQUEST: begin
        if (w_timeout) begin
          w_rsp_data_nxt  = 32'h0000_0000;
          w_rsp_error_nxt = 1'b1;
          w_bus_error     = 1'b1;
          w_sel_nxt       = '0;
          w_state_nxt     = ST_RESPOND;
        end else if (w_req_hit) begin
          w_cnt_nxt   = r_cnt + CW'(1);
          w_state_nxt = ST_WAIT_RSP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_WAIT_RSP: begin
        // A response arriving in the last counted cycle beats the timeout.
        if (w_rsp_hit) begin
          w_rsp_data_nxt  = (r_write || w_rerr) ? 32'h0000_0000 : w_rdata;
          w_rsp_error_nxt = w_rerr;
          w_sel_nxt       = '0;
          w_state_nxt     = ST_RESPOND;
        end else if (w_timeout) begin
          w_rsp_data_nxt  = 32'h0000_0000;
          w_rsp_error_nxt = 1'b1;
          w_bus_error     = 1'b1;
          w_sel_nxt       = '0;
          w_state_nxt     = ST_RESPOND;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_RESPOND: begin
        if (m_rsp_ready_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESPOND;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, payload and output registers; outputs are precomputed from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= ST_IDLE;
      r_sel            <= '0;
      r_cnt            <= '0;
      r_write          <= 1'b0;
      r_addr           <= 32'h0000_0000;
      r_wdata          <= 32'h0000_0000;
      r_strb           <= 4'h0;
      r_rsp_data       <= 32'h0000_0000;
      r_rsp_error      <= 1'b0;
      r_rsp_valid      <= 1'b0;
      r_req_ready      <= 1'b0;
      r_s_req_valid    <= '0;
      r_s_rsp_ready    <= '0;
      r_bus_error      <= 1'b0;
      r_bus_error_addr <= 32'h0000_0000;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_error <= w_rsp_error_nxt;
      if (w_latch) begin
        r_write <= m_req_write_i;
        r_addr  <= m_req_addr_i;
        r_wdata <= m_req_wdata_i;
        r_strb  <= m_req_strb_i;
      end
      if (w_bus_error) begin
        r_bus_error_addr <= r_addr;
      end
      r_bus_error   <= w_bus_error;
      r_req_ready   <= (w_state_nxt == ST_IDLE);
      r_rsp_valid   <= (w_state_nxt == ST_RESPOND);
      r_s_req_valid <= (w_state_nxt == ST_REQUEST) ? w_sel_nxt : '0;
      // Every slave not currently being requested may always drain a response.
      r_s_rsp_ready <= ~((w_state_nxt == ST_REQUEST) ? w_sel_nxt : '0);
    end
  end

  assign m_req_ready_o    = r_req_ready;
  assign m_rsp_valid_o    = r_rsp_valid;
  assign m_rsp_data_o     = r_rsp_data;
  assign m_rsp_error_o    = r_rsp_error;
  assign s_req_valid_o    = r_s_req_valid;
  assign s_req_write_o    = r_write;
  assign s_req_addr_o     = r_addr;
  assign s_req_wdata_o    = r_wdata;
  assign s_req_strb_o     = r_strb;
  assign s_rsp_ready_o    = r_s_rsp_ready;
  assign bus_error_o      = r_bus_error;
  assign bus_error_addr_o = r_bus_error_addr;

endmodule

// File: tb/tb_soc_bus_router.sv
// Bench for soc_bus_router: schedule-based transaction model with per-cycle output checks,
// directed corner cases and randomized traffic with stray slave responses.
module tb_soc_bus_router;

  localparam int NS = 3;
  localparam int TO = 16;
  localparam logic [31:0] LO [NS] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000};
  localparam logic [31:0] HI [NS] = '{32'h0000_0FFC, 32'h0000_100C, 32'h0000_2FFC};

  logic              clk;
  logic              rst_i;
  logic              m_req_valid_i, m_req_ready_o, m_req_write_i;
  logic [31:0]       m_req_addr_i, m_req_wdata_i;
  logic [3:0]        m_req_strb_i;
  logic              m_rsp_valid_o, m_rsp_ready_i, m_rsp_error_o;
  logic [31:0]       m_rsp_data_o;
  logic [NS-1:0]     s_req_valid_o, s_req_ready_i, s_rsp_valid_i, s_rsp_ready_o, s_rsp_error_i;
  logic              s_req_write_o;
  logic [31:0]       s_req_addr_o, s_req_wdata_o;
  logic [3:0]        s_req_strb_o;
  logic [32*NS-1:0]  s_rsp_data_i;
  logic              bus_error_o;
  logic [31:0]       bus_error_addr_o;

  soc_bus_router #(
    .SLAVES(NS), .LOW_ADDRESS(LO), .HIGH_ADDRESS(HI), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_req_valid_i(m_req_valid_i), .m_req_ready_o(m_req_ready_o), .m_req_write_i(m_req_write_i),
    .m_req_addr_i(m_req_addr_i), .m_req_wdata_i(m_req_wdata_i), .m_req_strb_i(m_req_strb_i),
    .m_rsp_valid_o(m_rsp_valid_o), .m_rsp_ready_i(m_rsp_ready_i), .m_rsp_data_o(m_rsp_data_o),
    .m_rsp_error_o(m_rsp_error_o), .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i),
    .s_req_write_o(s_req_write_o), .s_req_addr_o(s_req_addr_o), .s_req_wdata_o(s_req_wdata_o),
    .s_req_strb_o(s_req_strb_o), .s_rsp_valid_i(s_rsp_valid_i), .s_rsp_ready_o(s_rsp_ready_o),
    .s_rsp_data_i(s_rsp_data_i), .s_rsp_error_i(s_rsp_error_i), .bus_error_o(bus_error_o),
    .bus_error_addr_o(bus_error_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs for the current cycle, written by the stimulus process.
  logic          chk_en = 1'b0, e_zero = 1'b0;
  logic          e_req_ready, e_rsp_valid, e_rsp_err, e_write, e_bus_err;
  logic [31:0]   e_rsp_data, e_addr, e_wdata, e_bus_err_addr;
  logic [3:0]    e_strb;
  logic [NS-1:0] e_s_req_valid, e_s_rsp_ready, e_mask;
  logic [31:0]   m_last_err = 32'h0;

  int          obs_lat;
  logic [NS-1:0] obs_sel;
  logic [31:0] obs_data;
  logic        obs_err;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Single compare process: checks every output on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (e_zero) begin
        cmp("rst_m_req_ready", 32'(m_req_ready_o), 32'h0);
        cmp("rst_m_rsp_valid", 32'(m_rsp_valid_o), 32'h0);
        cmp("rst_m_rsp_data", m_rsp_data_o, 32'h0);
        cmp("rst_m_rsp_error", 32'(m_rsp_error_o), 32'h0);
        cmp("rst_s_req_valid", 32'(s_req_valid_o), 32'h0);
        cmp("rst_s_req_write", 32'(s_req_write_o), 32'h0);
        cmp("rst_s_req_addr", s_req_addr_o, 32'h0);
        cmp("rst_s_req_wdata", s_req_wdata_o, 32'h0);
        cmp("rst_s_req_strb", 32'(s_req_strb_o), 32'h0);
        cmp("rst_s_rsp_ready", 32'(s_rsp_ready_o), 32'h0);
        cmp("rst_bus_error", 32'(bus_error_o), 32'h0);
        cmp("rst_bus_error_addr", bus_error_addr_o, 32'h0);
      end else begin
        cmp("m_req_ready", 32'(m_req_ready_o), 32'(e_req_ready));
        cmp("m_rsp_valid", 32'(m_rsp_valid_o), 32'(e_rsp_valid));
        if (e_rsp_valid) begin
          cmp("m_rsp_data", m_rsp_data_o, e_rsp_data);
          cmp("m_rsp_error", 32'(m_rsp_error_o), 32'(e_rsp_err));
        end
        cmp("s_req_valid", 32'(s_req_valid_o), 32'(e_s_req_valid));
        if (e_s_req_valid != '0) begin
          cmp("s_req_write", 32'(s_req_write_o), 32'(e_write));
          cmp("s_req_addr", s_req_addr_o, e_addr);
          cmp("s_req_wdata", s_req_wdata_o, e_wdata);
          cmp("s_req_strb", 32'(s_req_strb_o), 32'(e_strb));
        end
        cmp("s_rsp_ready", 32'(s_rsp_ready_o & e_mask), 32'(e_s_rsp_ready & e_mask));
        cmp("bus_error", 32'(bus_error_o), 32'(e_bus_err));
        cmp("bus_error_addr", bus_error_addr_o, e_bus_err_addr);
      end
    end
  end

  function automatic int decode(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    for (int i = 0; i < NS; i++) begin
      if (w >= LO[i] && w <= HI[i]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_strays(input int idx);
    for (int i = 0; i < NS; i++) begin
      if (i != idx) begin
        s_rsp_valid_i[i]         = 1'($urandom_range(0, 1));
        s_req_ready_i[i]         = 1'($urandom_range(0, 1));
        s_rsp_error_i[i]         = 1'($urandom_range(0, 1));
        s_rsp_data_i[32*i +: 32] = $urandom;
      end
    end
  endtask

  task automatic set_idle_exp();
    chk_en = 1'b1; e_zero = 1'b0;
    e_req_ready = 1'b1; e_rsp_valid = 1'b0; e_s_req_valid = '0;
    e_s_rsp_ready = '1; e_mask = '1; e_bus_err = 1'b0; e_bus_err_addr = m_last_err;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      rst_i = 1'b0; m_req_valid_i = 1'b0;
      m_rsp_ready_i = 1'($urandom_range(0, 1));
      drive_strays(-1);
      set_idle_exp();
    end
  endtask

  // One transaction: d = cycles before slave ready, r = cycles after accept until response
  // (negative = never), m = cycles master stalls the response, rst_at = cycle of reset pulse.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int d, input int r,
                         input logic [31:0] rdata, input logic rerr, input int m, input int rst_at);
    int idx, tr, req_end, last_t;
    logic [NS-1:0] oh;
    logic [31:0] xdata;
    logic xerr, berr, in_req;
    idx = decode(addr);
    oh  = (idx >= 0) ? NS'(1) << idx : '0;
    if (idx < 0) begin
      tr = 2; xdata = 32'h0; xerr = 1'b1; berr = 1'b1; req_end = 0;
    end else if (r >= 1 && d <= TO - 2 && d + r <= TO - 1) begin
      tr = 3 + d + r; xdata = (wr || rerr) ? 32'h0 : rdata; xerr = rerr; berr = 1'b0;
      req_end = 2 + d;
    end else begin
      tr = 2 + TO; xdata = 32'h0; xerr = 1'b1; berr = 1'b1;
      req_end = (2 + d < 1 + TO) ? 2 + d : 1 + TO;
    end
    last_t = (rst_at >= 0) ? rst_at + 2 : tr + m;
    obs_lat = -1; obs_sel = '0; obs_data = 32'h0; obs_err = 1'b0;
    for (int t = 0; t <= last_t; t++) begin
      step();
      rst_i = (rst_at >= 0 && t == rst_at);
      if (t == 0) begin
        m_req_valid_i = 1'b1; m_req_write_i = wr; m_req_addr_i = addr;
        m_req_wdata_i = wdata; m_req_strb_i = strb;
      end else begin
        m_req_valid_i = (rst_at >= 0 && t > rst_at) ? 1'b0 : 1'($urandom_range(0, 1));
        m_req_write_i = 1'($urandom_range(0, 1)); m_req_addr_i = $urandom;
        m_req_wdata_i = $urandom; m_req_strb_i = 4'($urandom_range(0, 15));
      end
      m_rsp_ready_i = (t < tr) ? 1'($urandom_range(0, 1)) : (t == tr + m);
      drive_strays(idx);
      if (idx >= 0) begin
        s_req_ready_i[idx] = (t == 2 + d) && !(rst_at >= 0 && t > rst_at);
        s_rsp_error_i[idx] = rerr;
        if (rst_at >= 0 && t > rst_at) begin
          s_rsp_valid_i[idx] = 1'b0;
          s_rsp_data_i[32*idx +: 32] = $urandom;
        end else if (r >= 1 && t == 2 + d + r) begin
          s_rsp_valid_i[idx] = 1'b1;
          s_rsp_data_i[32*idx +: 32] = rdata;
        end else if (r < 0 && t == tr) begin
          s_rsp_valid_i[idx] = 1'b1;
          s_rsp_data_i[32*idx +: 32] = 32'hDEAD_BEEF;
        end else begin
          s_rsp_valid_i[idx] = 1'b0;
          s_rsp_data_i[32*idx +: 32] = $urandom;
        end
      end
      chk_en = 1'b1;
      if (rst_at >= 0 && t == rst_at + 1) begin
        e_zero = 1'b1; m_last_err = 32'h0;
      end else if (rst_at >= 0 && t == rst_at + 2) begin
        set_idle_exp();
      end else begin
        e_zero = 1'b0;
        in_req = (idx >= 0) && t >= 2 && t <= req_end;
        e_req_ready   = (t == 0);
        e_s_req_valid = in_req ? oh : '0;
        e_write = wr; e_addr = addr; e_wdata = wdata; e_strb = strb;
        e_s_rsp_ready = '1;
        e_mask        = (in_req || (idx >= 0 && t >= tr)) ? ~oh : '1;
        e_rsp_valid   = (t >= tr);
        e_rsp_data    = xdata;
        e_rsp_err     = xerr;
        e_bus_err     = (t == tr) && berr;
        if (t == tr && berr) m_last_err = addr;
        e_bus_err_addr = m_last_err;
      end
      if (m_rsp_valid_o && obs_lat < 0) begin
        obs_lat = t; obs_data = m_rsp_data_o; obs_err = m_rsp_error_o;
      end
      if (s_req_valid_o != '0 && obs_sel == '0) obs_sel = s_req_valid_o;
    end
  endtask

  initial begin
    int a, d, r, m;
    rst_i = 1'b1; m_req_valid_i = 1'b0; m_req_write_i = 1'b0; m_req_addr_i = 32'h0;
    m_req_wdata_i = 32'h0; m_req_strb_i = 4'h0; m_rsp_ready_i = 1'b0;
    s_req_ready_i = '0; s_rsp_valid_i = '0; s_rsp_error_i = '0; s_rsp_data_i = '0;
    step(); chk_en = 1'b1; e_zero = 1'b1;
    step();
    step(); rst_i = 1'b0;
    idle_cycles(2);

    run_txn(1'b0, 32'h0000_1008, 32'h0, 4'hF, 0, 1, 32'hCAFE_BABE, 1'b0, 0, -1);
    cmp("t1_sel", 32'(obs_sel), 32'h2);
    cmp("t1_latency", 32'(obs_lat), 32'd4);
    cmp("t1_data", obs_data, 32'hCAFE_BABE);
    cmp("t1_err", 32'(obs_err), 32'h0);

    run_txn(1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 4'b0011, 3, 2, 32'h5555_1111, 1'b0, 0, -1);
    cmp("t2_sel", 32'(obs_sel), 32'h1);
    cmp("t2_data", obs_data, 32'h0);
    cmp("t2_err", 32'(obs_err), 32'h0);
    idle_cycles(1);

    run_txn(1'b0, 32'h0000_1010, 32'h0, 4'hF, 0, 1, 32'h0, 1'b0, 0, -1);
    cmp("t3_sel", 32'(obs_sel), 32'h0);
    cmp("t3_latency", 32'(obs_lat), 32'd2);
    cmp("t3_err", 32'(obs_err), 32'h1);
    cmp("t3_err_addr", bus_error_addr_o, 32'h0000_1010);

    run_txn(1'b0, 32'h0000_2000, 32'h0, 4'hF, 0, -1, 32'h0, 1'b0, 1, -1);
    cmp("t4_latency", 32'(obs_lat), 32'd18);
    cmp("t4_err", 32'(obs_err), 32'h1);
    idle_cycles(1);
    run_txn(1'b0, 32'h0000_2004, 32'h0, 4'hF, 0, 1, 32'h1234_5678, 1'b0, 0, -1);
    cmp("t4_next_data", obs_data, 32'h1234_5678);

    run_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 1, 1, 32'h1122_3344, 1'b0, 5, -1);
    cmp("t5_latency", 32'(obs_lat), 32'd5);
    cmp("t5_data", obs_data, 32'h1122_3344);

    run_txn(1'b0, 32'h0000_2FFF, 32'h0, 4'hF, 0, TO - 1, 32'h0BAD_F00D, 1'b0, 0, -1);
    cmp("last_cycle_rsp_latency", 32'(obs_lat), 32'd18);
    cmp("last_cycle_rsp_err", 32'(obs_err), 32'h0);
    cmp("last_cycle_rsp_data", obs_data, 32'h0BAD_F00D);

    run_txn(1'b0, 32'h0000_100C, 32'h0, 4'hF, 0, 2, 32'h7777_0000, 1'b1, 0, -1);
    cmp("slave_err_data", obs_data, 32'h0);
    cmp("slave_err_flag", 32'(obs_err), 32'h1);

    run_txn(1'b0, 32'h0000_1004, 32'h0, 4'hF, 1, 10, 32'h9999_9999, 1'b0, 0, 5);
    idle_cycles(3);
    cmp("t6_no_response", 32'(obs_lat), 32'hFFFF_FFFF);

    for (int k = 0; k < 40; k++) begin
      a = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 32'h3100));
      d = int'($urandom_range(0, 5));
      case ($urandom_range(0, 9))
        0:       r = -1;
        1:       r = int'($urandom_range(8, 14));
        default: r = int'($urandom_range(1, 4));
      endcase
      m = int'($urandom_range(0, 3));
      run_txn(1'($urandom_range(0, 1)), 32'(a), $urandom, 4'($urandom_range(0, 15)), d, r,
              $urandom, ($urandom_range(0, 4) == 0), m, -1);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
